// File: rtl/shiftreg_seq_ctrl.sv
// Sequencing controller for an n-bit universal shift register: loads a parallel word, then shifts it out serially.
// Latency: bit 0 appears the cycle after the accepting edge; N bits, one done cycle, N+2 cycles per word.
// Backpressure: s_ready is high only in IDLE (and low while paused); a word is held by the producer until accepted.
// Optional feature: define SRCTRL_PAUSE_EN to add a pause input that freezes shifting without losing a bit.
module shiftreg_seq_ctrl #(
  parameter int   N    = 8,
  parameter logic FILL = 1'b0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [N-1:0] s_data,
  input  logic         s_msb_first,
`ifdef SRCTRL_PAUSE_EN
  input  logic         pause,
`endif
  output logic [1:0]   sr_sel,
  output logic [N-1:0] sr_in,
  output logic         sr_msb,
  output logic         sr_lsb,
  input  logic [N-1:0] sr_q,
  output logic         ser_out,
  output logic         ser_valid,
  output logic         busy,
  output logic         done
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  // Shift register sel encodings
  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_RIGHT = 2'b01;
  localparam logic [1:0] SEL_LEFT  = 2'b10;
  localparam logic [1:0] SEL_LOAD  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          dir;      // 1 = MSB first (shift left), 0 = LSB first (shift right)
  logic          pause_i;
  logic          hs;
  logic          shifting;

  // Only the two end bits of Q are observed; the rest is deliberately ignored.
  logic sr_q_unused;
  assign sr_q_unused = ^sr_q;

`ifdef SRCTRL_PAUSE_EN
  assign pause_i = pause;
`else
  assign pause_i = 1'b0;
`endif

  // Handshake and active-shift qualifiers
  assign s_ready  = (state == IDLE) && !pause_i;
  assign hs       = s_valid && s_ready;
  assign shifting = (state == SHIFT) && !pause_i;

  // Fill bits are constant; the parallel input always presents the offered word
  assign sr_msb = FILL;
  assign sr_lsb = FILL;
  assign sr_in  = s_data;

  // Serial output taps the end of Q that leaves the register first
  assign ser_out   = (state == SHIFT) && (dir ? sr_q[N-1] : sr_q[0]);
  assign ser_valid = shifting;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // Register command: load only on the accepting edge, shift only while actively shifting
  always_comb begin
    sr_sel = SEL_HOLD;
    case (state)
      IDLE:    sr_sel = hs ? SEL_LOAD : SEL_HOLD;
      SHIFT:   sr_sel = shifting ? (dir ? SEL_LEFT : SEL_RIGHT) : SEL_HOLD;
      default: sr_sel = SEL_HOLD;
    endcase
  end

  // Sequencer FSM: accept word, count N shifts, one done cycle, back to idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      dir   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hs) begin
            dir   <= s_msb_first;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (!pause_i) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shiftreg_seq_ctrl.sv
// Directed bench for shiftreg_seq_ctrl with a behavioural universal shift register closing the loop.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// Define SRCTRL_PAUSE_EN on both DUT and bench to exercise the pause scenario.
module tb_shiftreg_seq_ctrl;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         s_valid;
  logic         s_ready;
  logic [N-1:0] s_data;
  logic         s_msb_first;
`ifdef SRCTRL_PAUSE_EN
  logic         pause;
`endif
  logic [1:0]   sr_sel;
  logic [N-1:0] sr_in;
  logic         sr_msb;
  logic         sr_lsb;
  logic [N-1:0] sr_q = '0;
  logic         ser_out;
  logic         ser_valid;
  logic         busy;
  logic         done;

  int n_chk = 0;
  int n_err = 0;

  shiftreg_seq_ctrl #(.N(N), .FILL(1'b0)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_msb_first (s_msb_first),
`ifdef SRCTRL_PAUSE_EN
    .pause       (pause),
`endif
    .sr_sel      (sr_sel),
    .sr_in       (sr_in),
    .sr_msb      (sr_msb),
    .sr_lsb      (sr_lsb),
    .sr_q        (sr_q),
    .ser_out     (ser_out),
    .ser_valid   (ser_valid),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Behavioural universal shift register driven by the controller
  always @(posedge clk) begin
    case (sr_sel)
      2'b01:   sr_q <= {sr_msb, sr_q[N-1:1]};
      2'b10:   sr_q <= {sr_q[N-2:0], sr_lsb};
      2'b11:   sr_q <= sr_in;
      default: sr_q <= sr_q;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One full word: handshake, N bits in the order given by seq (seq[7] first), done, idle
  task automatic run_word(input string tag, input logic [7:0] data, input logic msbf,
                          input logic [7:0] seq);
    next_cycle();
    s_valid = 1'b1; s_data = data; s_msb_first = msbf;
    @(negedge clk);
    chk({tag, " hs_ready"}, s_ready, 1);
    chk({tag, " hs_sel"}, sr_sel, 2'b11);
    for (int i = 0; i < N; i++) begin
      next_cycle();
      // Direction flips and data changes mid-word must be ignored
      s_valid = 1'b0; s_data = 8'h5A; s_msb_first = ~msbf;
      @(negedge clk);
      chk($sformatf("%s bit%0d", tag, i), ser_out, seq[7-i]);
      chk($sformatf("%s vld%0d", tag, i), ser_valid, 1);
      chk($sformatf("%s sel%0d", tag, i), sr_sel, msbf ? 2'b10 : 2'b01);
      chk($sformatf("%s rdy%0d", tag, i), s_ready, 0);
    end
    next_cycle();
    @(negedge clk);
    chk({tag, " done"}, done, 1);
    chk({tag, " done_sel"}, sr_sel, 2'b00);
    chk({tag, " done_vld"}, ser_valid, 0);
    chk({tag, " done_rdy"}, s_ready, 0);
    chk({tag, " done_busy"}, busy, 1);
    next_cycle();
    @(negedge clk);
    chk({tag, " end_rdy"}, s_ready, 1);
    chk({tag, " end_done"}, done, 0);
    chk({tag, " end_busy"}, busy, 0);
  endtask

  initial begin
    reset_n = 1'b0; s_valid = 1'b0; s_data = '0; s_msb_first = 1'b0;
`ifdef SRCTRL_PAUSE_EN
    pause = 1'b0;
`endif
    repeat (2) next_cycle();
    @(negedge clk);
    chk("rst_sel", sr_sel, 2'b00);
    chk("rst_vld", ser_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rdy", s_ready, 1);
    chk("fill", {sr_msb, sr_lsb}, 2'b00);
    next_cycle();
    reset_n = 1'b1;

    // Idle with no valid: nothing moves
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      @(negedge clk);
      chk($sformatf("idle sel%0d", i), sr_sel, 2'b00);
      chk($sformatf("idle vld%0d", i), ser_valid, 0);
      chk($sformatf("idle busy%0d", i), busy, 0);
    end

    // A5 MSB first: 1,0,1,0,0,1,0,1 ; LSB first: bits 0..7 = 1,0,1,0,0,1,0,1
    run_word("a5_msb", 8'hA5, 1'b1, 8'b1010_0101);
    run_word("a5_lsb", 8'hA5, 1'b0, 8'b1010_0101);

    // Back-to-back FF then 00 with valid held: second handshake N+2 cycles after the first
    next_cycle();
    s_valid = 1'b1; s_data = 8'hFF; s_msb_first = 1'b1;
    @(negedge clk);
    chk("b2b hs0_sel", sr_sel, 2'b11);
    for (int c = 1; c <= 20; c++) begin
      next_cycle();
      if (c == 1) s_data = 8'h00;
      if (c == 11) s_valid = 1'b0;
      @(negedge clk);
      if (c <= 8) begin
        chk($sformatf("b2b w0 bit%0d", c - 1), ser_out, 1);
        chk($sformatf("b2b w0 sel%0d", c - 1), sr_sel, 2'b10);
      end else if (c == 9) begin
        chk("b2b w0 done", done, 1);
        chk("b2b w0 done_sel", sr_sel, 2'b00);
      end else if (c == 10) begin
        chk("b2b hs1_rdy", s_ready, 1);
        chk("b2b hs1_sel", sr_sel, 2'b11);
      end else if (c <= 18) begin
        chk($sformatf("b2b w1 bit%0d", c - 11), ser_out, 0);
        chk($sformatf("b2b w1 vld%0d", c - 11), ser_valid, 1);
      end else if (c == 19) begin
        chk("b2b w1 done", done, 1);
      end else begin
        chk("b2b end_rdy", s_ready, 1);
      end
    end

    // Reset after the 3rd bit of 3C (MSB first: 0,0,1), then 81 LSB first: 1,0,0,0,0,0,0,1
    next_cycle();
    s_valid = 1'b1; s_data = 8'h3C; s_msb_first = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      s_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("3c bit%0d", i), ser_out, (i == 2) ? 1 : 0);
    end
    next_cycle();
    reset_n = 1'b0;
    #1;
    chk("mid_rst vld", ser_valid, 0);
    chk("mid_rst busy", busy, 0);
    chk("mid_rst done", done, 0);
    chk("mid_rst rdy", s_ready, 1);
    chk("mid_rst sel", sr_sel, 2'b00);
    next_cycle();
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst rdy", s_ready, 1);
    chk("post_rst done", done, 0);
    run_word("81_lsb", 8'h81, 1'b0, 8'b1000_0001);

`ifdef SRCTRL_PAUSE_EN
    // Pause in idle blocks acceptance
    next_cycle();
    pause = 1'b1; s_valid = 1'b1; s_data = 8'hC3; s_msb_first = 1'b1;
    @(negedge clk);
    chk("pz idle_rdy", s_ready, 0);
    chk("pz idle_sel", sr_sel, 2'b00);
    // C3 MSB first = 1,1,0,0,0,0,1,1 ; pause 3 cycles after bit 2; done at cycle 12
    next_cycle();
    pause = 1'b0;
    @(negedge clk);
    chk("pz hs_sel", sr_sel, 2'b11);
    for (int c = 1; c <= 13; c++) begin
      next_cycle();
      s_valid = 1'b0;
      pause = (c >= 3 && c <= 5);
      @(negedge clk);
      if (c >= 3 && c <= 5) begin
        chk($sformatf("pz vld c%0d", c), ser_valid, 0);
        chk($sformatf("pz sel c%0d", c), sr_sel, 2'b00);
      end else if (c <= 11) begin
        chk($sformatf("pz vld c%0d", c), ser_valid, 1);
        chk($sformatf("pz bit c%0d", c), ser_out, (c == 1 || c == 2 || c >= 10) ? 1 : 0);
      end else if (c == 12) begin
        chk("pz done", done, 1);
      end else begin
        chk("pz end_rdy", s_ready, 1);
      end
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
